// File: rtl/sampling_layer1.sv
// 2x2 stride-2 float max-pooling over six parallel raster-scanned feature maps.
// All channels share one set of position counters; row pairs are merged through a half-width row buffer.
module sampling_layer1 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 24,
    parameter int IMG_HEIGHT = 24
) (
    input  logic                  Clock,
    input  logic                  Input_Reset,
    input  logic                  Input_Valid,
    input  logic                  Input_Finish,
    input  logic [DATA_WIDTH-1:0] Input_Pixel_1,
    input  logic [DATA_WIDTH-1:0] Input_Pixel_2,
    input  logic [DATA_WIDTH-1:0] Input_Pixel_3,
    input  logic [DATA_WIDTH-1:0] Input_Pixel_4,
    input  logic [DATA_WIDTH-1:0] Input_Pixel_5,
    input  logic [DATA_WIDTH-1:0] Input_Pixel_6,
    output logic [DATA_WIDTH-1:0] Output_Pixel_1,
    output logic [DATA_WIDTH-1:0] Output_Pixel_2,
    output logic [DATA_WIDTH-1:0] Output_Pixel_3,
    output logic [DATA_WIDTH-1:0] Output_Pixel_4,
    output logic [DATA_WIDTH-1:0] Output_Pixel_5,
    output logic [DATA_WIDTH-1:0] Output_Pixel_6,
    output logic                  Output_Valid,
    output logic                  Output_Finish
);

    localparam int NUM_CH    = 6;
    localparam int HALF_W    = IMG_WIDTH / 2;
    localparam int OUT_TOTAL = HALF_W * (IMG_HEIGHT / 2);
    localparam int CW        = $clog2(IMG_WIDTH);
    localparam int RW        = $clog2(IMG_HEIGHT);
    localparam int OW        = $clog2(OUT_TOTAL);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(OUT_TOTAL - 1);

    logic [DATA_WIDTH-1:0] pix_in  [NUM_CH];
    logic [DATA_WIDTH-1:0] pix_out [NUM_CH];
    logic [DATA_WIDTH-1:0] hold    [NUM_CH];
    logic [DATA_WIDTH-1:0] rowbuf  [NUM_CH][HALF_W];
    logic [DATA_WIDTH-1:0] pair    [NUM_CH];
    logic [DATA_WIDTH-1:0] quad    [NUM_CH];

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [OW-1:0] out_cnt;
    logic [CW-2:0] buf_idx;
    logic          accept;
    logic          window_done;
    logic          frame_done;

    // Bit-pattern float max; operand a is always the earlier pixel in scan order and wins ties.
    function automatic logic [DATA_WIDTH-1:0] fmax(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic                  sa;
        logic                  sb;
        logic [DATA_WIDTH-2:0] ma;
        logic [DATA_WIDTH-2:0] mb;
        sa = a[DATA_WIDTH-1];
        sb = b[DATA_WIDTH-1];
        ma = a[DATA_WIDTH-2:0];
        mb = b[DATA_WIDTH-2:0];
        if (ma == '0 && mb == '0)
            return a;
        else if (sa != sb)
            return sa ? b : a;
        else if (!sa)
            return (mb > ma) ? b : a;
        else
            return (mb < ma) ? b : a;
    endfunction

    assign pix_in[0] = Input_Pixel_1;
    assign pix_in[1] = Input_Pixel_2;
    assign pix_in[2] = Input_Pixel_3;
    assign pix_in[3] = Input_Pixel_4;
    assign pix_in[4] = Input_Pixel_5;
    assign pix_in[5] = Input_Pixel_6;

    assign Output_Pixel_1 = pix_out[0];
    assign Output_Pixel_2 = pix_out[1];
    assign Output_Pixel_3 = pix_out[2];
    assign Output_Pixel_4 = pix_out[3];
    assign Output_Pixel_5 = pix_out[4];
    assign Output_Pixel_6 = pix_out[5];

    assign accept      = Input_Valid & ~Input_Finish;
    assign buf_idx     = col[CW-1:1];
    assign window_done = col[0] & row[0];
    assign frame_done  = window_done && (out_cnt == OUT_LAST);

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pair[ch] = fmax(hold[ch], pix_in[ch]);
            quad[ch] = fmax(rowbuf[ch][buf_idx], pair[ch]);
        end
    end

    always_ff @(posedge Clock or posedge Input_Reset) begin
        if (Input_Reset) begin
            col           <= '0;
            row           <= '0;
            out_cnt       <= '0;
            Output_Valid  <= 1'b0;
            Output_Finish <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                hold[ch]    <= '0;
                pix_out[ch] <= '0;
                for (int i = 0; i < HALF_W; i++)
                    rowbuf[ch][i] <= '0;
            end
        end else begin
            Output_Valid <= 1'b0;
            if (accept) begin
                // Any accepted pixel after a finished frame starts the next one, so finish only survives
                // the edge that produces the frame's last output.
                Output_Finish <= frame_done;

                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (!col[0])
                        hold[ch] <= pix_in[ch];
                    else if (!row[0])
                        rowbuf[ch][buf_idx] <= pair[ch];
                    else
                        pix_out[ch] <= quad[ch];
                end

                if (window_done) begin
                    Output_Valid <= 1'b1;
                    out_cnt      <= frame_done ? '0 : out_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sampling_layer1.sv
// Directed bench for sampling_layer1: ascending frames, sign/zero/tie patterns, finish hold, bubbles, mid-frame reset.
module tb_sampling_layer1;

    logic        Clock = 1'b0;
    logic        Input_Reset;
    logic        Input_Valid;
    logic        Input_Finish;
    logic [31:0] px [6];
    logic [31:0] Output_Pixel_1, Output_Pixel_2, Output_Pixel_3;
    logic [31:0] Output_Pixel_4, Output_Pixel_5, Output_Pixel_6;
    logic        Output_Valid;
    logic        Output_Finish;

    int total = 0;
    int bad   = 0;

    logic [191:0] cap [$];
    logic         fcap [$];

    always #5 Clock = ~Clock;

    sampling_layer1 dut (
        .Clock          (Clock),
        .Input_Reset    (Input_Reset),
        .Input_Valid    (Input_Valid),
        .Input_Finish   (Input_Finish),
        .Input_Pixel_1  (px[0]),
        .Input_Pixel_2  (px[1]),
        .Input_Pixel_3  (px[2]),
        .Input_Pixel_4  (px[3]),
        .Input_Pixel_5  (px[4]),
        .Input_Pixel_6  (px[5]),
        .Output_Pixel_1 (Output_Pixel_1),
        .Output_Pixel_2 (Output_Pixel_2),
        .Output_Pixel_3 (Output_Pixel_3),
        .Output_Pixel_4 (Output_Pixel_4),
        .Output_Pixel_5 (Output_Pixel_5),
        .Output_Pixel_6 (Output_Pixel_6),
        .Output_Valid   (Output_Valid),
        .Output_Finish  (Output_Finish)
    );

    always @(negedge Clock) begin
        if (Output_Valid === 1'b1) begin
            cap.push_back({Output_Pixel_6, Output_Pixel_5, Output_Pixel_4,
                           Output_Pixel_3, Output_Pixel_2, Output_Pixel_1});
            fcap.push_back(Output_Finish);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic f);
        Input_Valid  = v;
        Input_Finish = f;
        @(posedge Clock);
        #1;
    endtask

    // kind 0: ascending on all channels; kind 1: one distinct corner case per channel.
    function automatic logic [31:0] gen(input int kind, input int ch, input int i);
        int c;
        c = i % 24;
        if (kind == 0) return 32'h3F800000 + 32'(i);
        case (ch)
            0: return (i == 0) ? 32'hBF800000 : 32'hC0000000;
            1: return (i == 0) ? 32'h80000000 : 32'h00000000;
            2: return 32'hBF800000 + 32'(i);
            3: return (c % 2 == 0) ? 32'h3F000000 + 32'(i) : 32'hC0000000 + 32'(i);
            4: return 32'h40000000 - 32'(i);
            default: return 32'h3F800000 + 32'(i);
        endcase
    endfunction

    function automatic logic [31:0] expv(input int kind, input int ch, input int k);
        int tl;
        tl = (k / 12) * 48 + (k % 12) * 2;
        if (kind == 0) return 32'h3F800000 + 32'(tl + 25);
        case (ch)
            0: return (k == 0) ? 32'hBF800000 : 32'hC0000000;
            1: return (k == 0) ? 32'h80000000 : 32'h00000000;
            2: return 32'hBF800000 + 32'(tl);
            3: return 32'h3F000000 + 32'(tl + 24);
            4: return 32'h40000000 - 32'(tl);
            default: return 32'h3F800000 + 32'(tl + 25);
        endcase
    endfunction

    task automatic send(input int kind, input int start, input int n, input bit bubbles);
        for (int i = start; i < start + n; i++) begin
            if (bubbles && i != start && $urandom_range(0, 2) == 0) begin
                for (int ch = 0; ch < 6; ch++) px[ch] = $urandom;
                if ($urandom_range(0, 1) == 0) step(1'b0, 1'b0);
                else                           step(1'b1, 1'b1);
            end
            for (int ch = 0; ch < 6; ch++) px[ch] = gen(kind, ch, i);
            step(1'b1, 1'b0);
        end
        Input_Valid = 1'b0;
    endtask

    task automatic check_frame(input int kind, input int base, input string name);
        int early;
        logic [191:0] w;
        early = 0;
        for (int k = 0; k < 144 && base + k < cap.size(); k++) begin
            w = cap[base + k];
            for (int ch = 0; ch < 6; ch++)
                chk($sformatf("%s_k%0d_ch%0d", name, k, ch + 1), w[ch*32 +: 32], expv(kind, ch, k));
            if (k < 143 && fcap[base + k] !== 1'b0) early++;
        end
        chk({name, "_finish_early"}, 32'(early), 32'd0);
        if (base + 143 < cap.size())
            chk({name, "_finish_last"}, {31'd0, fcap[base + 143]}, 32'd1);
        else
            chk({name, "_finish_last_missing"}, 32'(cap.size()), 32'(base + 144));
    endtask

    initial begin
        Input_Reset  = 1'b1;
        Input_Valid  = 1'b0;
        Input_Finish = 1'b0;
        for (int ch = 0; ch < 6; ch++) px[ch] = 32'h0;
        @(posedge Clock);
        #1;
        chk("rst_valid", {31'd0, Output_Valid}, 32'd0);
        chk("rst_finish", {31'd0, Output_Finish}, 32'd0);
        chk("rst_pix1", Output_Pixel_1, 32'd0);
        chk("rst_pix6", Output_Pixel_6, 32'd0);
        @(posedge Clock);
        #1;
        Input_Reset = 1'b0;

        // Frame 1: gapless ascending.
        cap.delete(); fcap.delete();
        send(0, 0, 575, 1'b0);
        chk("f1_no_early_finish", {31'd0, Output_Finish}, 32'd0);
        send(0, 575, 1, 1'b0);
        chk("f1_last_valid", {31'd0, Output_Valid}, 32'd1);
        chk("f1_last_finish", {31'd0, Output_Finish}, 32'd1);
        chk("f1_last_pix", Output_Pixel_1, 32'h3F80023F);
        step(1'b0, 1'b0);
        chk("f1_count", 32'(cap.size()), 32'd144);
        check_frame(0, 0, "f1");
        chk("f1_out0", cap.size() > 0 ? cap[0][31:0] : 32'hx, 32'h3F800019);
        chk("f1_idle_valid", {31'd0, Output_Valid}, 32'd0);
        chk("f1_hold_pix", Output_Pixel_1, 32'h3F80023F);

        // Input_Finish blocks acceptance.
        cap.delete(); fcap.delete();
        for (int i = 0; i < 20; i++) begin
            for (int ch = 0; ch < 6; ch++) px[ch] = $urandom;
            step(1'b1, 1'b1);
        end
        step(1'b0, 1'b0);
        chk("fin_hold_count", 32'(cap.size()), 32'd0);
        chk("fin_hold_finish", {31'd0, Output_Finish}, 32'd1);
        chk("fin_hold_pix", Output_Pixel_1, 32'h3F80023F);

        // Frame 2 (corner cases) followed back-to-back by frame 3 (ascending with bubbles).
        cap.delete(); fcap.delete();
        send(1, 0, 1, 1'b0);
        chk("f2_finish_cleared", {31'd0, Output_Finish}, 32'd0);
        send(1, 1, 25, 1'b0);
        chk("f2_first_valid", {31'd0, Output_Valid}, 32'd1);
        chk("f2_first_pix1", Output_Pixel_1, 32'hBF800000);
        chk("f2_first_pix2", Output_Pixel_2, 32'h80000000);
        send(1, 26, 1, 1'b0);
        chk("f2_valid_one_cycle", {31'd0, Output_Valid}, 32'd0);
        send(1, 27, 549, 1'b0);
        send(0, 0, 576, 1'b1);
        step(1'b0, 1'b0);
        chk("f23_count", 32'(cap.size()), 32'd288);
        check_frame(1, 0, "f2");
        check_frame(0, 144, "f3");

        // Asynchronous reset in the middle of a frame.
        cap.delete(); fcap.delete();
        send(0, 0, 300, 1'b0);
        #3 Input_Reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, Output_Valid}, 32'd0);
        chk("mid_rst_finish", {31'd0, Output_Finish}, 32'd0);
        chk("mid_rst_pix1", Output_Pixel_1, 32'd0);
        chk("mid_rst_pix4", Output_Pixel_4, 32'd0);
        @(posedge Clock);
        #1;
        Input_Reset = 1'b0;
        cap.delete(); fcap.delete();
        send(0, 0, 576, 1'b0);
        step(1'b0, 1'b0);
        chk("f4_count", 32'(cap.size()), 32'd144);
        check_frame(0, 0, "f4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
